// File: rtl/smc_intadd_pkg.sv
// smc_intadd_pkg: mode codes and the stage-2 clamp/overflow function shared by the int-add slice.
package smc_intadd_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_LEGACY = 2'b10;

    // Widest element the clamp function handles; callers pass their real width in e.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] r;
    } sat_res_t;

    function automatic sat_res_t sat_clip(input logic signed [MAX_W+1:0] s, input logic dom_signed,
                                          input logic [1:0] mode, input int e);
        logic signed [MAX_W+1:0] one, smin, hi, lo, mask, clamped, pick;
        sat_res_t res;
        one     = 1;
        smin    = -(one <<< (e - 1));
        hi      = dom_signed ? (one <<< (e - 1)) - one : (one <<< e) - one;
        lo      = dom_signed ? smin : '0;
        mask    = (one <<< e) - one;
        clamped = (s > hi) ? hi : (s < lo) ? lo : s;
        // s below the signed minimum is only reachable when both operands are negative
        pick    = (mode == MODE_SAT) ? clamped :
                  (mode == MODE_LEGACY && s < smin) ? -one : s;
        res.ovf = (s > hi) || (s < lo);
        res.r   = MAX_W'(pick & mask);
        return res;
    endfunction

endpackage

// File: rtl/smc_intadd_lane.sv
// smc_intadd_lane: extends one lane's half-width A and full-width B and adds them at ELEM_W+2 bits.
module smc_intadd_lane #(
    parameter int ELEM_W = 8
) (
    input  logic [ELEM_W/2-1:0]     a,
    input  logic [ELEM_W-1:0]       b,
    input  logic                    sign_a,
    input  logic                    sign_b,
    output logic signed [ELEM_W+1:0] sum
);
    localparam int HALF_W = ELEM_W / 2;

    logic signed [ELEM_W+1:0] ax, bx;

    assign ax  = {{(ELEM_W + 2 - HALF_W){sign_a & a[HALF_W-1]}}, a};
    assign bx  = {{2{sign_b & b[ELEM_W-1]}}, b};
    assign sum = ax + bx;

endmodule

// File: rtl/smc_intadd_pipe.sv
// smc_intadd_pipe: two-stage valid/ready SIMD adder (half-width A + full-width B per lane)
// with wrap/saturate/legacy result modes and per-lane sticky overflow flags.
module smc_intadd_pipe
    import smc_intadd_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ELEM_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            src0,
    input  logic [DATA_W-1:0]            src1,
    input  logic [DATA_W-1:0]            src2,
    input  logic                         sign_s0,
    input  logic                         sign_s1,
    input  logic                         sign_s2,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            dst0,
    output logic [DATA_W-1:0]            dst1,
    output logic [DATA_W/(ELEM_W/2)-1:0] ovf,
    output logic [DATA_W/(ELEM_W/2)-1:0] ovf_sticky,
    input  logic                         sticky_clr
);
    localparam int HALF_W = ELEM_W / 2;
    localparam int LANES  = DATA_W / HALF_W;

    logic                     s1_valid, s2_valid, s1_dom, s2_free, s2_load;
    logic [1:0]               s1_mode;
    logic signed [ELEM_W+1:0] sum    [LANES];
    logic signed [ELEM_W+1:0] s1_sum [LANES];
    logic [DATA_W-1:0]        r_lo, r_hi;
    logic [LANES-1:0]         ovf_new;
    logic                     unused_sign_s1;

    assign unused_sign_s1 = sign_s1;
    assign s2_free        = !s2_valid | out_ready;
    assign s2_load        = s1_valid & s2_free;
    assign in_ready       = !s1_valid | s2_free;
    assign out_valid      = s2_valid;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_res_t res;
        logic     unused_hi;
        smc_intadd_lane #(.ELEM_W(ELEM_W)) u_lane (
            .a      (src0[i*HALF_W +: HALF_W]),
            .b      ({src2[i*HALF_W +: HALF_W], src1[i*HALF_W +: HALF_W]}),
            .sign_a (sign_s0),
            .sign_b (sign_s2),
            .sum    (sum[i])
        );
        assign res                       = sat_clip((MAX_W + 2)'(s1_sum[i]), s1_dom, s1_mode, ELEM_W);
        assign r_lo[i*HALF_W +: HALF_W]  = res.r[HALF_W-1:0];
        assign r_hi[i*HALF_W +: HALF_W]  = res.r[ELEM_W-1:HALF_W];
        assign ovf_new[i]                = res.ovf;
        assign unused_hi                 = ^res.r[MAX_W-1:ELEM_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dom   <= 1'b0;
            s1_mode  <= MODE_WRAP;
            for (int i = 0; i < LANES; i++) s1_sum[i] <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum  <= sum;
                s1_dom  <= sign_s0 | sign_s2;
                s1_mode <= mode;
            end
        end
    end

    // A clear coinciding with a load still keeps the flags that load raises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            dst0       <= '0;
            dst1       <= '0;
            ovf        <= '0;
            ovf_sticky <= '0;
        end else begin
            if (s2_free) s2_valid <= s1_valid;
            if (s2_load) begin
                dst0       <= r_lo;
                dst1       <= r_hi;
                ovf        <= ovf_new;
                ovf_sticky <= (sticky_clr ? '0 : ovf_sticky) | ovf_new;
            end else if (sticky_clr) begin
                ovf_sticky <= '0;
            end
        end
    end

endmodule

// File: tb/tb_smc_intadd_pipe.sv
// tb_smc_intadd_pipe: directed table-driven checks of the int-add pipe at 8-bit and 16-bit elements.
module tb_smc_intadd_pipe;

    typedef struct {
        logic [3:0] a;
        logic [7:0] b;
        logic       s0, s1, s2;
        logic [1:0] m;
        logic [7:0] r;
        logic       o;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] b;
        logic        s0, s2;
        logic [1:0]  m;
        logic [15:0] r;
        logic        o;
    } wvec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b1, sticky_clr = 1'b0;
    logic         sign_s0 = 1'b0, sign_s1 = 1'b0, sign_s2 = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [127:0] src0 = '0, src1 = '0, src2 = '0;
    logic         in_ready, out_valid;
    logic [127:0] dst0, dst1;
    logic [31:0]  ovf, ovf_sticky;

    logic         w_in_valid = 1'b0, w_out_ready = 1'b1, w_clr = 1'b0, w_s1 = 1'b0;
    logic         w_s0 = 1'b0, w_s2 = 1'b0;
    logic [1:0]   w_mode = 2'b00;
    logic [63:0]  w_src0 = '0, w_src1 = '0, w_src2 = '0;
    logic         w_in_ready, w_out_valid;
    logic [63:0]  w_dst0, w_dst1;
    logic [7:0]   w_ovf, w_sticky;

    int checks = 0;
    int errors = 0;

    smc_intadd_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src0(src0), .src1(src1), .src2(src2),
        .sign_s0(sign_s0), .sign_s1(sign_s1), .sign_s2(sign_s2), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .dst0(dst0), .dst1(dst1),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr)
    );

    smc_intadd_pipe #(.DATA_W(64), .ELEM_W(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .src0(w_src0), .src1(w_src1), .src2(w_src2),
        .sign_s0(w_s0), .sign_s1(w_s1), .sign_s2(w_s2), .mode(w_mode),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .dst0(w_dst0), .dst1(w_dst1),
        .ovf(w_ovf), .ovf_sticky(w_sticky), .sticky_clr(w_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [127:0] rep4(input logic [3:0] x);
        return {32{x}};
    endfunction

    function automatic logic [63:0] rep8(input logic [7:0] x);
        return {8{x}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Drives one beat at a negedge into an empty pipe and returns at the negedge where it appears.
    task automatic send(input logic [127:0] a0, input logic [127:0] a1, input logic [127:0] a2,
                        input logic sa, input logic sr, input logic sb, input logic [1:0] m,
                        input logic clr);
        int lat;
        src0 = a0; src1 = a1; src2 = a2;
        sign_s0 = sa; sign_s1 = sr; sign_s2 = sb; mode = m;
        sticky_clr = clr; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 4 && lat < 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
        end
        chk("latency", 128'(lat), 128'd1);
    endtask

    task automatic send_w(input wvec_t v);
        int lat;
        w_src0 = rep8(v.a); w_src1 = rep8(v.b[7:0]); w_src2 = rep8(v.b[15:8]);
        w_s0 = v.s0; w_s2 = v.s2; w_mode = v.m; w_in_valid = 1'b1;
        @(posedge clk);
        #1 w_in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 4 && lat < 0; i++) begin
            @(negedge clk);
            if (w_out_valid) lat = i;
        end
        chk("w_latency", 128'(lat), 128'd1);
    endtask

    vec_t  tv [20];
    wvec_t wv [6];

    initial begin
        logic seen;
        tv[0]  = '{4'h7, 8'h7F, 1'b1, 1'b0, 1'b1, 2'b00, 8'h86, 1'b1};
        tv[1]  = '{4'h7, 8'h7F, 1'b1, 1'b0, 1'b1, 2'b01, 8'h7F, 1'b1};
        tv[2]  = '{4'h7, 8'h7F, 1'b1, 1'b0, 1'b1, 2'b10, 8'h86, 1'b1};
        tv[3]  = '{4'h7, 8'h7F, 1'b1, 1'b0, 1'b1, 2'b11, 8'h86, 1'b1};
        tv[4]  = '{4'h8, 8'h80, 1'b1, 1'b0, 1'b1, 2'b00, 8'h78, 1'b1};
        tv[5]  = '{4'h8, 8'h80, 1'b1, 1'b0, 1'b1, 2'b01, 8'h80, 1'b1};
        tv[6]  = '{4'h8, 8'h80, 1'b1, 1'b0, 1'b1, 2'b10, 8'hFF, 1'b1};
        tv[7]  = '{4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b00, 8'h0E, 1'b1};
        tv[8]  = '{4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b01, 8'hFF, 1'b1};
        tv[9]  = '{4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b10, 8'h0E, 1'b1};
        tv[10] = '{4'h3, 8'h10, 1'b0, 1'b0, 1'b0, 2'b00, 8'h13, 1'b0};
        tv[11] = '{4'h3, 8'h10, 1'b0, 1'b0, 1'b0, 2'b01, 8'h13, 1'b0};
        tv[12] = '{4'h3, 8'h10, 1'b0, 1'b0, 1'b0, 2'b10, 8'h13, 1'b0};
        tv[13] = '{4'h3, 8'h10, 1'b0, 1'b1, 1'b0, 2'b01, 8'h13, 1'b0};
        tv[14] = '{4'h7, 8'h7F, 1'b1, 1'b1, 1'b1, 2'b01, 8'h7F, 1'b1};
        tv[15] = '{4'hF, 8'h80, 1'b1, 1'b0, 1'b1, 2'b10, 8'hFF, 1'b1};
        tv[16] = '{4'hF, 8'h80, 1'b1, 1'b0, 1'b1, 2'b00, 8'h7F, 1'b1};
        tv[17] = '{4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 8'hFF, 1'b0};
        tv[18] = '{4'h1, 8'hFF, 1'b1, 1'b0, 1'b0, 2'b01, 8'h7F, 1'b1};
        tv[19] = '{4'h1, 8'hFF, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1};
        wv[0]  = '{8'h7F, 16'h7FFF, 1'b1, 1'b1, 2'b01, 16'h7FFF, 1'b1};
        wv[1]  = '{8'h7F, 16'h7FFF, 1'b1, 1'b1, 2'b00, 16'h807E, 1'b1};
        wv[2]  = '{8'h80, 16'h8000, 1'b1, 1'b1, 2'b10, 16'hFFFF, 1'b1};
        wv[3]  = '{8'h80, 16'h8000, 1'b1, 1'b1, 2'b00, 16'h7F80, 1'b1};
        wv[4]  = '{8'hFF, 16'hFFFF, 1'b0, 1'b0, 2'b01, 16'hFFFF, 1'b1};
        wv[5]  = '{8'h03, 16'h0010, 1'b0, 1'b0, 2'b00, 16'h0013, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_dst0", dst0, 128'd0);
        chk("rst_sticky", 128'(ovf_sticky), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < 20; i++) begin
            send(rep4(tv[i].a), rep4(tv[i].b[3:0]), rep4(tv[i].b[7:4]),
                 tv[i].s0, tv[i].s1, tv[i].s2, tv[i].m, 1'b0);
            chk($sformatf("v%0d_dst0", i), dst0, rep4(tv[i].r[3:0]));
            chk($sformatf("v%0d_dst1", i), dst1, rep4(tv[i].r[7:4]));
            chk($sformatf("v%0d_ovf", i), 128'(ovf), 128'({32{tv[i].o}}));
        end

        // backpressure: three beats 0x11, 0x12, 0x13 while the consumer stalls
        @(negedge clk);
        out_ready = 1'b0; sign_s0 = 1'b0; sign_s1 = 1'b0; sign_s2 = 1'b0; mode = 2'b00;
        src1 = rep4(4'h0); src2 = rep4(4'h1); src0 = rep4(4'h1); in_valid = 1'b1;
        chk("bp_ready_first", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 src0 = rep4(4'h2);
        chk("bp_ready_second", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 src0 = rep4(4'h3);
        @(negedge clk);
        chk("bp_ready_full", 128'(in_ready), 128'd0);
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        chk("bp_dst0_head", dst0, rep4(4'h1));
        repeat (2) @(negedge clk);
        chk("bp_dst0_stable", dst0, rep4(4'h1));
        chk("bp_dst1_stable", dst1, rep4(4'h1));
        chk("bp_ready_still", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                chk($sformatf("bp_valid%0d", k), 128'(out_valid), 128'd1);
                chk($sformatf("bp_order%0d", k), dst0, rep4(4'(k + 1)));
            end else begin
                chk("bp_no_dup", 128'(out_valid), 128'd0);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
        end

        // sticky flags: lanes 2 and 5 overflow, then clear+lane-5 overflow, then clear alone
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_clear0", 128'(ovf_sticky), 128'd0);
        send((128'h7 << 20) | (128'h7 << 8), (128'hF << 20) | (128'hF << 8),
             (128'h7 << 20) | (128'h7 << 8), 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        chk("sticky_ovf25", 128'(ovf), 128'h24);
        chk("sticky_set25", 128'(ovf_sticky), 128'h24);
        repeat (3) @(negedge clk);
        chk("sticky_persist", 128'(ovf_sticky), 128'h24);
        send(128'h7 << 20, 128'hF << 20, 128'h7 << 20, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
        sticky_clr = 1'b0;
        chk("sticky_clr_and_set", 128'(ovf_sticky), 128'h20);
        @(negedge clk);
        chk("sticky_hold5", 128'(ovf_sticky), 128'h20);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_clr_alone", 128'(ovf_sticky), 128'd0);

        // reset with two overflowing beats held
        out_ready = 1'b0; src0 = rep4(4'h7); src1 = rep4(4'hF); src2 = rep4(4'h7);
        sign_s0 = 1'b1; sign_s2 = 1'b1; mode = 2'b00; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_held", 128'(out_valid), 128'd1);
        chk("rst2_sticky_pre", 128'(ovf_sticky), 128'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", 128'(out_valid), 128'd0);
        chk("rst2_dst0", dst0, 128'd0);
        chk("rst2_dst1", dst1, 128'd0);
        chk("rst2_ovf", 128'(ovf), 128'd0);
        chk("rst2_sticky", 128'(ovf_sticky), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("rst2_no_stale", 128'(seen), 128'd0);
        chk("rst2_in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < 6; i++) begin
            send_w(wv[i]);
            chk($sformatf("w%0d_dst0", i), 128'(w_dst0), 128'(rep8(wv[i].r[7:0])));
            chk($sformatf("w%0d_dst1", i), 128'(w_dst1), 128'(rep8(wv[i].r[15:8])));
            chk($sformatf("w%0d_ovf", i), 128'(w_ovf), 128'({8{wv[i].o}}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
